uart_apb_arbiter: RTL and testbench
===================================

Name: uart_apb_arbiter

Overview:
- Two-requester APB master that shares the UART peripheral's single APB slave port (status / TX / RX registers).
- Arbitrates round-robin between two on-chip requesters.
- Sequences each transfer through APB SETUP/ACCESS phases and waits on Pready. The UART RX read stalls Pready until a byte arrives.
- Aborts any transfer that exceeds a configurable timeout and reports the error to the owning requester.

Parameters:
- c_TIMEOUT, 2000, max ACCESS cycles before abort. 0 disables the timeout. Default exceeds one 115200-baud frame at 10 MHz (870 clocks).
- c_TIMEOUT_W, 16, width of the timeout counter.

Ports:
- i_Pclk  in  1  clock. Rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Req0 / i_Req1  in  1  request. Held high until the matching ack.
- i_Wr0 / i_Wr1  in  1  1 = write, 0 = read.
- i_Addr0 / i_Addr1  in  2  UART register select: 00 status, 01 TX, 10 RX.
- i_Wdata0 / i_Wdata1  in  8  write data.
- o_Ack0 / o_Ack1  out  1  one-cycle transfer-complete pulse.
- o_Err0 / o_Err1  out  1  one-cycle timeout pulse, coincident with ack.
- o_Rdata0 / o_Rdata1  out  8  read data. Valid in the ack cycle and held until the next ack to that requester.
- o_Paddr  out  32  [31:30] = selected address, [29:0] = 0.
- o_Psel  out  1  APB select.
- o_Penable  out  1  APB enable.
- o_Pwrite  out  1  APB direction.
- o_Pwdata  out  8  APB write data.
- i_Pready  in  1  slave ready.
- i_Prdata  in  8  slave read data.
- o_Busy  out  1  high in any state except IDLE.
- o_Grant  out  1  index of the current or last owner.

Behaviour:
- Reset (asynchronous, any state, including mid-transfer):
  - State IDLE; all outputs 0; round-robin pointer favours requester 0; timeout counter 0.
  - An aborted transfer produces no ack.
- All outputs are registered.
- States: IDLE -> SETUP -> ACCESS -> DONE -> IDLE.
- IDLE:
  - Psel = Penable = 0.
  - If any request is high, pick the winner:
    - Only one requesting: that one wins.
    - Both requesting: the pointer-favoured one wins.
  - Latch the winner's Wr/Addr/Wdata into o_Pwrite/o_Paddr/o_Pwdata; set o_Grant; go to SETUP.
- SETUP (exactly 1 cycle): Psel = 1, Penable = 0; go to ACCESS.
- ACCESS:
  - Psel = 1, Penable = 1. Counter increments each cycle.
  - i_Pready = 1 at a clock edge:
    - Capture i_Prdata into the owner's o_Rdata (read only; writes leave o_Rdata unchanged).
    - Go to DONE.
  - Otherwise, if c_TIMEOUT != 0 and counter == c_TIMEOUT-1: go to DONE flagged as error; owner's o_Rdata is forced to 0x00.
  - Pready and timeout in the same cycle: Pready wins, no error.
- DONE (1 cycle):
  - Psel = Penable = 0.
  - Owner's o_Ack = 1; o_Err = 1 if timed out.
  - Pointer flips to favour the other requester, even after an error.
  - Counter clears. Go to IDLE.
- Requester contract: drop Req at the clock edge where Ack is sampled high, so IDLE never re-grants a stale request.
- Paddr/Pwrite/Pwdata are stable from SETUP through ACCESS. They hold their values in DONE/IDLE until the next grant.
- Minimum latency, request in IDLE to ack: 3 cycles (IDLE edge -> SETUP -> ACCESS with Pready -> DONE). Full cycle back to IDLE is 4 cycles.
- Back-to-back: a request held during DONE is taken in the following IDLE cycle. Round-robin guarantees alternation when both requesters are continuously requesting.
- Requests that change while not in IDLE are ignored until IDLE.
- The non-owner's ack/err/rdata never change during another requester's transfer.

Test Plan:
- Basic write:
  - Stimulus: Req0 write, Addr 00, Wdata 0x07; slave returns Pready one cycle into ACCESS.
  - Required: Paddr = 0x00000000, Pwdata = 0x07; Psel/Penable sequence 10 then 11; Ack0 pulse exactly 3 cycles after the request edge; Err0 = 0; Ack1 stays 0.
- Stalled read:
  - Stimulus: Req1 read, Addr 10; Pready delayed 870 cycles with Prdata = 0x53.
  - Required: Paddr = 0x80000000; Penable held high throughout; o_Rdata1 = 0x53 in the Ack1 cycle; no error.
- Contention:
  - Stimulus: Req0 and Req1 both asserted from reset and held (re-raised after each ack).
  - Required: grants alternate 0,1,0,1; each ack reaches the correct requester; o_Grant matches.
- Timeout (c_TIMEOUT = 16):
  - Stimulus: read with Pready never asserted.
  - Required: DONE after 16 ACCESS cycles; Ack0 = Err0 = 1; o_Rdata0 = 0x00; Psel drops; the next grant goes to requester 1.
- Pready on the timeout cycle:
  - Stimulus: Pready asserted exactly at cycle 16 with Prdata 0xD6.
  - Required: Err = 0; Rdata = 0xD6.
- Reset mid-transfer:
  - Stimulus: assert i_Reset during ACCESS, asynchronously (between clock edges).
  - Required: Psel/Penable/Busy go to 0 immediately; no ack. After release, a pending Req1 with Req0 low is granted normally.

Source files
------------

// File: rtl/uart_apb_arbiter.sv
// uart_apb_arbiter: round-robin APB master sharing the UART's single APB
// slave port between two on-chip requesters, with an ACCESS-phase timeout.
//
// Ports:
//   i_Pclk, i_Reset            clock (rising edge), async active-high reset
//   i_Req0/1, i_Wr0/1          request (held until ack), 1 = write
//   i_Addr0/1, i_Wdata0/1      UART register select (00 status/01 TX/10 RX), write data
//   o_Ack0/1, o_Err0/1         one-cycle completion pulse, timeout flag with ack
//   o_Rdata0/1                 read data, valid from ack until next ack to that requester
//   o_Paddr..o_Pwdata          APB master outputs; i_Pready/i_Prdata from slave
//   o_Busy, o_Grant            not-idle flag, current/last owner index
module uart_apb_arbiter #(
    parameter int unsigned c_TIMEOUT   = 2000,
    parameter int unsigned c_TIMEOUT_W = 16
) (
    input  logic        i_Pclk,
    input  logic        i_Reset,
    input  logic        i_Req0,
    input  logic        i_Req1,
    input  logic        i_Wr0,
    input  logic        i_Wr1,
    input  logic [1:0]  i_Addr0,
    input  logic [1:0]  i_Addr1,
    input  logic [7:0]  i_Wdata0,
    input  logic [7:0]  i_Wdata1,
    output logic        o_Ack0,
    output logic        o_Ack1,
    output logic        o_Err0,
    output logic        o_Err1,
    output logic [7:0]  o_Rdata0,
    output logic [7:0]  o_Rdata1,
    output logic [31:0] o_Paddr,
    output logic        o_Psel,
    output logic        o_Penable,
    output logic        o_Pwrite,
    output logic [7:0]  o_Pwdata,
    input  logic        i_Pready,
    input  logic [7:0]  i_Prdata,
    output logic        o_Busy,
    output logic        o_Grant
);

    // Last ACCESS count value before abort; unused when the timeout is disabled.
    localparam logic [c_TIMEOUT_W-1:0] c_LIMIT = c_TIMEOUT_W'(c_TIMEOUT - 1);
    localparam logic c_TIMEOUT_EN = (c_TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                  r_state, state_nxt;
    logic [c_TIMEOUT_W-1:0]  r_cnt, cnt_nxt;
    logic                    r_prio, prio_nxt;   // 0 favours requester 0
    logic                    win;

    logic        ack0_nxt, ack1_nxt, err0_nxt, err1_nxt;
    logic [7:0]  rdata0_nxt, rdata1_nxt;
    logic [31:0] paddr_nxt;
    logic        psel_nxt, penable_nxt, pwrite_nxt, busy_nxt, grant_nxt;
    logic [7:0]  pwdata_nxt;

    // State and registered outputs.
    always_ff @(posedge i_Pclk or posedge i_Reset) begin
        if (i_Reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_prio    <= 1'b0;
            o_Ack0    <= 1'b0;
            o_Ack1    <= 1'b0;
            o_Err0    <= 1'b0;
            o_Err1    <= 1'b0;
            o_Rdata0  <= 8'h00;
            o_Rdata1  <= 8'h00;
            o_Paddr   <= 32'h0;
            o_Psel    <= 1'b0;
            o_Penable <= 1'b0;
            o_Pwrite  <= 1'b0;
            o_Pwdata  <= 8'h00;
            o_Busy    <= 1'b0;
            o_Grant   <= 1'b0;
        end else begin
            r_state   <= state_nxt;
            r_cnt     <= cnt_nxt;
            r_prio    <= prio_nxt;
            o_Ack0    <= ack0_nxt;
            o_Ack1    <= ack1_nxt;
            o_Err0    <= err0_nxt;
            o_Err1    <= err1_nxt;
            o_Rdata0  <= rdata0_nxt;
            o_Rdata1  <= rdata1_nxt;
            o_Paddr   <= paddr_nxt;
            o_Psel    <= psel_nxt;
            o_Penable <= penable_nxt;
            o_Pwrite  <= pwrite_nxt;
            o_Pwdata  <= pwdata_nxt;
            o_Busy    <= busy_nxt;
            o_Grant   <= grant_nxt;
        end
    end

    // Next state and next registered output values.
    always_comb begin
        state_nxt   = r_state;
        cnt_nxt     = r_cnt;
        prio_nxt    = r_prio;
        win         = 1'b0;
        ack0_nxt    = 1'b0;
        ack1_nxt    = 1'b0;
        err0_nxt    = 1'b0;
        err1_nxt    = 1'b0;
        rdata0_nxt  = o_Rdata0;
        rdata1_nxt  = o_Rdata1;
        paddr_nxt   = o_Paddr;
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
        pwrite_nxt  = o_Pwrite;
        pwdata_nxt  = o_Pwdata;
        grant_nxt   = o_Grant;

        case (r_state)
            IDLE: begin
                if (i_Req0 || i_Req1) begin
                    // Pointer only matters when both request.
                    win        = (i_Req0 && i_Req1) ? r_prio : i_Req1;
                    grant_nxt  = win;
                    pwrite_nxt = win ? i_Wr1 : i_Wr0;
                    paddr_nxt  = {(win ? i_Addr1 : i_Addr0), 30'd0};
                    pwdata_nxt = win ? i_Wdata1 : i_Wdata0;
                    psel_nxt   = 1'b1;
                    state_nxt  = SETUP;
                end
            end
            SETUP: begin
                psel_nxt    = 1'b1;
                penable_nxt = 1'b1;
                state_nxt   = ACCESS;
            end
            ACCESS: begin
                cnt_nxt = r_cnt + c_TIMEOUT_W'(1);
                if (i_Pready) begin
                    // Pready beats a coincident timeout.
                    state_nxt = DONE;
                    ack0_nxt  = !o_Grant;
                    ack1_nxt  = o_Grant;
                    if (!o_Pwrite) begin
                        if (o_Grant) rdata1_nxt = i_Prdata;
                        else         rdata0_nxt = i_Prdata;
                    end
                end else if (c_TIMEOUT_EN && (r_cnt == c_LIMIT)) begin
                    state_nxt = DONE;
                    ack0_nxt  = !o_Grant;
                    ack1_nxt  = o_Grant;
                    err0_nxt  = !o_Grant;
                    err1_nxt  = o_Grant;
                    if (o_Grant) rdata1_nxt = 8'h00;
                    else         rdata0_nxt = 8'h00;
                end else begin
                    psel_nxt    = 1'b1;
                    penable_nxt = 1'b1;
                end
            end
            DONE: begin
                prio_nxt  = !o_Grant;
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_uart_apb_arbiter.sv
// Scoreboard bench for uart_apb_arbiter. Two instances share the bench's
// APB slave model: index 0 uses the default timeout, index 1 uses 16.
// Requests are steered to the instance selected by sel.
module tb_uart_apb_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         sel = 0;

    logic       req   [2];
    logic       wr    [2];
    logic [1:0] addr  [2];
    logic [7:0] wdata [2];
    logic       pready = 1'b0;
    logic [7:0] prdata = 8'h00;

    logic        a0_w [2], a1_w [2], e0_w [2], e1_w [2];
    logic [7:0]  rd0_w [2], rd1_w [2], pwd_w [2];
    logic [31:0] pa_w [2];
    logic        ps_w [2], pe_w [2], pw_w [2], bz_w [2], gr_w [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        uart_apb_arbiter #(
            .c_TIMEOUT   ((g == 0) ? 2000 : 16),
            .c_TIMEOUT_W (16)
        ) u_dut (
            .i_Pclk    (clk),
            .i_Reset   (rst),
            .i_Req0    (req[0] && (sel == g)),
            .i_Req1    (req[1] && (sel == g)),
            .i_Wr0     (wr[0]),
            .i_Wr1     (wr[1]),
            .i_Addr0   (addr[0]),
            .i_Addr1   (addr[1]),
            .i_Wdata0  (wdata[0]),
            .i_Wdata1  (wdata[1]),
            .o_Ack0    (a0_w[g]),
            .o_Ack1    (a1_w[g]),
            .o_Err0    (e0_w[g]),
            .o_Err1    (e1_w[g]),
            .o_Rdata0  (rd0_w[g]),
            .o_Rdata1  (rd1_w[g]),
            .o_Paddr   (pa_w[g]),
            .o_Psel    (ps_w[g]),
            .o_Penable (pe_w[g]),
            .o_Pwrite  (pw_w[g]),
            .o_Pwdata  (pwd_w[g]),
            .i_Pready  (pready),
            .i_Prdata  (prdata),
            .o_Busy    (bz_w[g]),
            .o_Grant   (gr_w[g])
        );
    end

    // Selected instance's outputs.
    wire        ack0    = a0_w[sel];
    wire        ack1    = a1_w[sel];
    wire        err0    = e0_w[sel];
    wire        err1    = e1_w[sel];
    wire [7:0]  rdata0  = rd0_w[sel];
    wire [7:0]  rdata1  = rd1_w[sel];
    wire [31:0] paddr   = pa_w[sel];
    wire        psel    = ps_w[sel];
    wire        penable = pe_w[sel];
    wire        pwrite  = pw_w[sel];
    wire [7:0]  pwdata  = pwd_w[sel];
    wire        busy    = bz_w[sel];
    wire        grant   = gr_w[sel];

    typedef struct {
        int         who;
        logic       err;
        logic [7:0] rd;
        int         nacc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Slave model: Pready in the sl_delay-th ACCESS cycle (0 = never).
    int         sl_delay = 1;
    logic [7:0] sl_rdata = 8'h00;
    int         acc_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int who, input logic err, input logic [7:0] rd, input int nacc);
        exp_t e;
        e.who = who; e.err = err; e.rd = rd; e.nacc = nacc;
        return e;
    endfunction

    always @(negedge clk) begin
        if (psel && !penable) acc_cnt = 0;
        if (psel && penable) begin
            acc_cnt++;
            pready = (sl_delay != 0) && (acc_cnt == sl_delay);
        end else begin
            pready = 1'b0;
        end
        prdata = sl_rdata;
    end

    // Monitor: compare every ack against the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && (ack0 || ack1)) begin
            if (q.size() == 0) begin
                chk("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("ack_single", {30'd0, ack1, ack0}, (e.who == 1) ? 32'd2 : 32'd1);
                chk("ack_grant", grant, e.who);
                chk("ack_psel_low", {psel, penable}, 0);
                chk("ack_err", (e.who == 1) ? err1 : err0, e.err);
                chk("ack_other_err", (e.who == 1) ? err0 : err1, 0);
                chk("ack_rdata", (e.who == 1) ? rdata1 : rdata0, e.rd);
                chk("ack_access_cycles", acc_cnt, e.nacc);
            end
        end
    end

    task automatic run_txn(input int idx, input logic wr_i, input logic [1:0] ad,
                           input logic [7:0] wd, input bit chk_setup, output int lat);
        wr[idx] = wr_i; addr[idx] = ad; wdata[idx] = wd; req[idx] = 1'b1;
        lat = 0;
        while (1) begin
            @(negedge clk);
            lat++;
            if (chk_setup && lat == 1) begin
                chk("setup_psel_penable", {psel, penable}, 32'd2);
                chk("setup_paddr", paddr, {ad, 30'd0});
                chk("setup_pwrite", pwrite, wr_i);
                if (wr_i) chk("setup_pwdata", pwdata, wd);
                chk("setup_grant", grant, idx);
                chk("setup_busy", busy, 1);
            end
            if (chk_setup && lat == 2)
                chk("access_psel_penable", {psel, penable}, 32'd3);
            if ((idx == 0 && ack0) || (idx == 1 && ack1)) break;
            if (lat >= 3000) begin
                checks++; errors++;
                $display("FAIL ack_wait req%0d actual=no_ack expected=ack", idx);
                break;
            end
        end
        @(posedge clk);
        req[idx] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; wr[i] = 1'b0; addr[i] = 2'b00; wdata[i] = 8'h00;
        end
        repeat (2) @(negedge clk);

        // Reset values.
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_ack", {ack1, ack0, err1, err0}, 0);
        chk("rst_rdata", {rdata1, rdata0}, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata_pwrite", {pwdata, pwrite}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic write: status reg, 0x07, Pready in first ACCESS cycle.
        sl_delay = 1; sl_rdata = 8'hEE;
        q.push_back(mk(0, 1'b0, 8'h00, 1));
        run_txn(0, 1'b1, 2'b00, 8'h07, 1'b1, lat);
        chk("write_latency", lat, 3);

        // Stalled RX read: 870 stall cycles, then 0x53.
        sl_delay = 871; sl_rdata = 8'h53;
        q.push_back(mk(1, 1'b0, 8'h53, 871));
        run_txn(1, 1'b0, 2'b10, 8'h00, 1'b1, lat);

        // Contention: req0 writes, req1 reads; grants alternate 0,1,0,1,0,1.
        sl_delay = 2; sl_rdata = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            q.push_back(mk(0, 1'b0, 8'h00, 2));
            q.push_back(mk(1, 1'b0, 8'hA5, 2));
        end
        fork
            begin
                int l0;
                for (int i = 0; i < 3; i++) run_txn(0, 1'b1, 2'b01, 8'h10 + 8'(i), 1'b0, l0);
            end
            begin
                int l1;
                for (int i = 0; i < 3; i++) run_txn(1, 1'b0, 2'b10, 8'h00, 1'b0, l1);
            end
        join

        // Reset during ACCESS, asserted between clock edges.
        sl_delay = 0;
        wr[1] = 1'b0; addr[1] = 2'b10; req[1] = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_access", {psel, penable}, 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_psel_penable_busy", {psel, penable, busy}, 0);
        repeat (2) @(negedge clk);
        chk("rst_rdata_cleared", {rdata1, rdata0}, 0);
        sl_delay = 1; sl_rdata = 8'h3C;
        q.push_back(mk(1, 1'b0, 8'h3C, 1));
        rst = 1'b0;
        run_txn(1, 1'b0, 2'b10, 8'h00, 1'b1, lat);
        chk("post_rst_latency", lat, 3);

        // Short-timeout instance.
        sel = 1;
        @(negedge clk);

        // Timeout: Pready never arrives.
        sl_delay = 0; sl_rdata = 8'h99;
        q.push_back(mk(0, 1'b1, 8'h00, 16));
        run_txn(0, 1'b0, 2'b10, 8'h00, 1'b1, lat);
        chk("timeout_latency", lat, 18);

        // After the error the pointer favours requester 1.
        sl_delay = 1; sl_rdata = 8'h11;
        q.push_back(mk(1, 1'b0, 8'h11, 1));
        q.push_back(mk(0, 1'b0, 8'h00, 1));
        fork
            begin
                int l0;
                run_txn(0, 1'b1, 2'b01, 8'h5A, 1'b0, l0);
            end
            begin
                int l1;
                run_txn(1, 1'b0, 2'b00, 8'h00, 1'b0, l1);
            end
        join

        // Pready on the final allowed ACCESS cycle wins over the timeout.
        sl_delay = 16; sl_rdata = 8'hD6;
        q.push_back(mk(0, 1'b0, 8'hD6, 16));
        run_txn(0, 1'b0, 2'b10, 8'h00, 1'b1, lat);

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        chk("final_idle", {busy, psel, penable}, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
